uart_cfg_ctrl: RTL and testbench

Configuration sequencer for the UART datapath. Takes the raw BAUD/EIGHT/PEN/OHEL switch levels delivered by the top-level input buffers and synchronizes and debounces them. It commits a new configuration to the transmitter, receiver and baud generator only when both are idle, so a frame is never corrupted mid-flight. It sits between the I/O buffer layer and the UART core.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_cfg_ctrl_if.sv | 28 ++
 rtl/cfg_sync.sv | 26 ++
 rtl/uart_cfg_ctrl.sv | 121 ++++++++++++
 tb/tb_uart_cfg_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, reset defaults and baud divisor table for the UART config sequencer
package uart_pkg;

    localparam int BAUD_K_W = 19;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2,
        APPLY  = 2'd3
    } cfg_state_e;

    typedef struct packed {
        logic [3:0] baud;
        logic       eight;
        logic       pen;
        logic       ohel;
    } cfg_word_t;

    localparam logic [3:0]          RESET_BAUD_CODE = 4'd4;
    localparam logic                RESET_EIGHT     = 1'b1;
    localparam logic                RESET_PEN       = 1'b0;
    localparam logic                RESET_OHEL      = 1'b0;
    localparam logic [BAUD_K_W-1:0] RESET_BAUD_K    = 19'd10417;
    localparam cfg_word_t           RESET_WORD      = '{RESET_BAUD_CODE, RESET_EIGHT, RESET_PEN, RESET_OHEL};

    // 100 MHz divided by the selected bit rate, rounded; codes 11-15 all map to the fastest rate
    function automatic logic [BAUD_K_W-1:0] baud_k(input logic [3:0] code);
        case (code)
            4'd0:    return 19'd333333;
            4'd1:    return 19'd83333;
            4'd2:    return 19'd41667;
            4'd3:    return 19'd20833;
            4'd4:    return 19'd10417;
            4'd5:    return 19'd5208;
            4'd6:    return 19'd2604;
            4'd7:    return 19'd1736;
            4'd8:    return 19'd868;
            4'd9:    return 19'd434;
            4'd10:   return 19'd217;
            default: return 19'd109;
        endcase
    endfunction

endpackage

// File: rtl/uart_cfg_ctrl_if.sv
// rtl/uart_cfg_ctrl_if.sv - switch, busy and committed-configuration signals of the UART config sequencer
interface uart_cfg_ctrl_if;
    import uart_pkg::*;

    logic [3:0]          baud_sw;
    logic                eight_sw;
    logic                pen_sw;
    logic                ohel_sw;
    logic                tx_busy;
    logic                rx_busy;
    logic                uart_hold;
    logic                cfg_load;
    logic [BAUD_K_W-1:0] cfg_baud_k;
    logic                cfg_eight;
    logic                cfg_pen;
    logic                cfg_ohel;

    modport master (
        output baud_sw, eight_sw, pen_sw, ohel_sw, tx_busy, rx_busy,
        input  uart_hold, cfg_load, cfg_baud_k, cfg_eight, cfg_pen, cfg_ohel
    );

    modport slave (
        input  baud_sw, eight_sw, pen_sw, ohel_sw, tx_busy, rx_busy,
        output uart_hold, cfg_load, cfg_baud_k, cfg_eight, cfg_pen, cfg_ohel
    );

endinterface

// File: rtl/cfg_sync.sv
// rtl/cfg_sync.sv - parameterized-width two-flop synchronizer with asynchronous active-low reset
module cfg_sync #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_cfg_ctrl.sv
// rtl/uart_cfg_ctrl.sv - debounced UART configuration commit sequencer; UART_CFG_DEBOUNCE_EN builds the settle counter
module uart_cfg_ctrl
    import uart_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           reset,
    uart_cfg_ctrl_if.slave cfg_if
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    cfg_word_t           raw_w;
    cfg_word_t           sync_w;
    cfg_word_t           snap_q;
    cfg_word_t           commit_q;
    cfg_state_e          state_q;
    logic [BAUD_K_W-1:0] baud_k_q;
    logic                load_q;
    logic                hold_q;
    logic [1:0]          vld_q;
    logic                settle_done;

    assign raw_w = '{cfg_if.baud_sw, cfg_if.eight_sw, cfg_if.pen_sw, cfg_if.ohel_sw};

    cfg_sync #(.WIDTH(7)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (raw_w),
        .q_o   (sync_w)
    );

`ifdef UART_CFG_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    logic [CNT_W-1:0] cnt_q;
    assign settle_done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
`else
    assign settle_done = 1'b1;
`endif

    // vld_q blocks the IDLE compare until the synchronizer has flushed its reset zeros
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            snap_q   <= RESET_WORD;
            commit_q <= RESET_WORD;
            baud_k_q <= RESET_BAUD_K;
            load_q   <= 1'b0;
            hold_q   <= 1'b0;
            vld_q    <= 2'b00;
`ifdef UART_CFG_DEBOUNCE_EN
            cnt_q    <= '0;
`endif
        end else begin
            vld_q  <= {vld_q[0], 1'b1};
            load_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (vld_q[1] && (sync_w != commit_q)) begin
                        snap_q  <= sync_w;
                        state_q <= SETTLE;
`ifdef UART_CFG_DEBOUNCE_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (sync_w != snap_q) begin
                        snap_q <= sync_w;
`ifdef UART_CFG_DEBOUNCE_EN
                        cnt_q  <= '0;
`endif
                    end else if (settle_done) begin
                        // a value that settled back onto the committed word is a rejected glitch
                        if (snap_q == commit_q) begin
                            state_q <= IDLE;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= HOLD;
                            hold_q  <= 1'b1;
                        end
                    end else begin
`ifdef UART_CFG_DEBOUNCE_EN
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (sync_w != snap_q) begin
                        snap_q  <= sync_w;
                        state_q <= SETTLE;
`ifdef UART_CFG_DEBOUNCE_EN
                        cnt_q   <= '0;
`endif
                    end else if (!cfg_if.tx_busy && !cfg_if.rx_busy) begin
                        state_q  <= APPLY;
                        commit_q <= snap_q;
                        baud_k_q <= baud_k(snap_q.baud);
                        load_q   <= 1'b1;
                    end
                end
                APPLY: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_if.uart_hold  = hold_q;
    assign cfg_if.cfg_load   = load_q;
    assign cfg_if.cfg_baud_k = baud_k_q;
    assign cfg_if.cfg_eight  = commit_q.eight;
    assign cfg_if.cfg_pen    = commit_q.pen;
    assign cfg_if.cfg_ohel   = commit_q.ohel;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// tb/tb_uart_cfg_ctrl.sv - scoreboard bench for uart_cfg_ctrl (settle length follows UART_CFG_DEBOUNCE_EN)
module tb_uart_cfg_ctrl;

`ifdef UART_CFG_DEBOUNCE_EN
    localparam int D     = 16;
    localparam int PULSE = 5;
`else
    localparam int D     = 1;
    localparam int PULSE = 1;
`endif

    typedef struct {
        int          cyc;
        logic [18:0] k;
        logic        e;
        logic        p;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   hold_cnt = 0;
    exp_t sb[$];

    uart_cfg_ctrl_if bus();

    uart_cfg_ctrl #(.DEBOUNCE_CYCLES(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .cfg_if (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int c, input logic [18:0] k, input logic e, input logic p, input logic o);
        exp_t x;
        x.cyc = c; x.k = k; x.e = e; x.p = p; x.o = o;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (reset && bus.cfg_load) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_cfg_load: got load at cycle %0d expected none", cyc);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("load_cycle", cyc, x.cyc);
                chk("load_baud_k", 32'(bus.cfg_baud_k), 32'(x.k));
                chk("load_eight", 32'(bus.cfg_eight), 32'(x.e));
                chk("load_pen", 32'(bus.cfg_pen), 32'(x.p));
                chk("load_ohel", 32'(bus.cfg_ohel), 32'(x.o));
            end
        end
        if (bus.uart_hold) hold_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, r, h0, low;
        bus.baud_sw  = 4'd4;
        bus.eight_sw = 1'b1;
        bus.pen_sw   = 1'b0;
        bus.ohel_sw  = 1'b0;
        bus.tx_busy  = 1'b0;
        bus.rx_busy  = 1'b0;

        // reset state, then release with switches at defaults
        tick(3);
        chk("rst_hold", 32'(bus.uart_hold), 0);
        chk("rst_load", 32'(bus.cfg_load), 0);
        chk("rst_baud_k", 32'(bus.cfg_baud_k), 10417);
        chk("rst_eight", 32'(bus.cfg_eight), 1);
        chk("rst_pen", 32'(bus.cfg_pen), 0);
        chk("rst_ohel", 32'(bus.cfg_ohel), 0);
        reset = 1'b1;
        h0 = hold_cnt;
        tick(100);
        chk("idle_hold_cycles", hold_cnt - h0, 0);
        chk("idle_baud_k", 32'(bus.cfg_baud_k), 10417);

        // baud 4 -> 8 with UART idle
        c = cyc;
        bus.baud_sw = 4'd8;
        push(c + 4 + D, 19'd868, 1'b1, 1'b0, 1'b0);
        at_cycle(c + 2 + D); chk("b8_hold_pre", 32'(bus.uart_hold), 0);
        at_cycle(c + 3 + D); chk("b8_hold_hold", 32'(bus.uart_hold), 1);
        at_cycle(c + 4 + D); chk("b8_hold_apply", 32'(bus.uart_hold), 1);
        at_cycle(c + 5 + D); chk("b8_hold_post", 32'(bus.uart_hold), 0);
        tick(5);
        chk("b8_baud_k", 32'(bus.cfg_baud_k), 868);

        // short pen pulse is rejected
        h0 = hold_cnt;
        bus.pen_sw = 1'b1;
        tick(PULSE);
        bus.pen_sw = 1'b0;
        tick(D + 20);
        chk("glitch_hold_cycles", hold_cnt - h0, 0);
        chk("glitch_pen", 32'(bus.cfg_pen), 0);

        // eight 1 -> 0 while transmitter busy for 200 cycles
        bus.tx_busy = 1'b1;
        c = cyc;
        bus.eight_sw = 1'b0;
        at_cycle(c + 4 + D); chk("tx_hold_early", 32'(bus.uart_hold), 1);
        at_cycle(c + 199);   chk("tx_hold_late", 32'(bus.uart_hold), 1);
        at_cycle(c + 200);
        bus.tx_busy = 1'b0;
        push(c + 201, 19'd868, 1'b0, 1'b0, 1'b0);
        at_cycle(c + 201); chk("tx_hold_apply", 32'(bus.uart_hold), 1);
        at_cycle(c + 202); chk("tx_hold_post", 32'(bus.uart_hold), 0);
        chk("tx_eight", 32'(bus.cfg_eight), 0);

        // baud changes again during HOLD while receiver busy; only the final value commits
        bus.rx_busy = 1'b1;
        c = cyc;
        bus.baud_sw = 4'd2;
        at_cycle(c + 4 + D); chk("rx_hold_first", 32'(bus.uart_hold), 1);
        c2 = cyc;
        bus.baud_sw = 4'd11;
        low = 0;
        for (int k = 1; k <= D + 8; k++) begin
            at_cycle(c2 + k);
            if (!bus.uart_hold) low++;
        end
        chk("rx_hold_low_cycles", low, 0);
        r = cyc;
        bus.rx_busy = 1'b0;
        push(r + 1, 19'd109, 1'b0, 1'b0, 1'b0);
        at_cycle(r + 2); chk("rx_hold_post", 32'(bus.uart_hold), 0);
        chk("rx_baud_k", 32'(bus.cfg_baud_k), 109);

        // reset asserted mid-HOLD
        bus.tx_busy = 1'b1;
        c = cyc;
        bus.baud_sw = 4'd0;
        at_cycle(c + 4 + D); chk("rh_hold", 32'(bus.uart_hold), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rh_hold_cleared", 32'(bus.uart_hold), 0);
        chk("rh_load", 32'(bus.cfg_load), 0);
        chk("rh_baud_k", 32'(bus.cfg_baud_k), 10417);
        chk("rh_eight", 32'(bus.cfg_eight), 1);
        chk("rh_pen", 32'(bus.cfg_pen), 0);
        chk("rh_ohel", 32'(bus.cfg_ohel), 0);
        bus.baud_sw  = 4'd4;
        bus.eight_sw = 1'b1;
        bus.tx_busy  = 1'b0;
        tick(3);
        reset = 1'b1;
        h0 = hold_cnt;
        tick(100);
        chk("rh_idle_hold_cycles", hold_cnt - h0, 0);
        chk("rh_idle_baud_k", 32'(bus.cfg_baud_k), 10417);

        chk("sb_pending", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
